stage3_kernel_scheduler: RTL and testbench

//  Sequences the stage-3 CI-input MAC kernel (2-cycle latency, one dot product per valid) over one frame.

---
 rtl/stage3_kernel_scheduler_pkg.sv | 34 +++
 rtl/stage3_sat_round.sv | 25 ++
 rtl/stage3_kernel_scheduler.sv | 177 +++++++++++++++++
 tb/tb_stage3_kernel_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage3_kernel_scheduler_pkg.sv
// Shared sizing and state encoding for the stage-3 kernel scheduler slice.
// Every derived width lives here so the top and the saturator stay consistent.
package stage3_kernel_scheduler_pkg;

  // Kernel geometry and datapath widths
  localparam int CI     = 3;   // input channels per pooled vector
  localparam int OF_BW  = 16;  // signed pooled feature width
  localparam int W_BW   = 8;   // signed weight width
  localparam int MUL_BW = 24;  // kernel product width
  localparam int KLEN   = 4;   // pooled vectors per frame
  localparam int CO     = 3;   // output channels per frame
  localparam int OUT_BW = 16;  // saturated output width

  // Derived widths
  localparam int KR_BW   = MUL_BW + 2;            // kernel result width
  localparam int ACC_BW  = KR_BW + $clog2(KLEN);  // accumulator, wide enough for KLEN results
  localparam int POOL_BW = CI * OF_BW;
  localparam int WGT_BW  = CI * W_BW;
  localparam int ADDR_BW = $clog2(CO * KLEN);
  localparam int IDX_BW  = $clog2(CO);
  localparam int K_BW    = $clog2(KLEN);
  localparam int RCNT_BW = $clog2(KLEN + 1);      // must be able to hold KLEN itself

  // Frame sequencing states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_OUT   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/stage3_sat_round.sv
// Clamps a signed accumulator value into the signed OUT_BW output range.
// The accumulator carries no fractional bits, so no rounding step is needed.
module stage3_sat_round #(
  parameter int IN_BW  = 28,
  parameter int OUT_BW = 16
) (
  input  logic signed [IN_BW-1:0]  in_data,
  output logic signed [OUT_BW-1:0] out_data
);

  // Largest and smallest representable outputs, expressed at the input width
  localparam logic signed [IN_BW-1:0] MAX_V = {{(IN_BW-OUT_BW+1){1'b0}}, {(OUT_BW-1){1'b1}}};
  localparam logic signed [IN_BW-1:0] MIN_V = {{(IN_BW-OUT_BW+1){1'b1}}, {(OUT_BW-1){1'b0}}};

  // Clamp to the output range, otherwise pass the low bits through unchanged
  always_comb begin
    out_data = in_data[OUT_BW-1:0];
    if (in_data > MAX_V) begin
      out_data = MAX_V[OUT_BW-1:0];
    end else if (in_data < MIN_V) begin
      out_data = MIN_V[OUT_BW-1:0];
    end
  end

endmodule

// File: rtl/stage3_kernel_scheduler.sv
// Stage-3 kernel scheduler: buffers KLEN pooled vectors, then for each output
// channel streams KLEN (feature, weight) pairs into the external MAC kernel,
// sums the returned dot products and hands one saturated value downstream.
module stage3_kernel_scheduler
  import stage3_kernel_scheduler_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_clear,
  input  logic               i_pool_valid,
  output logic               o_pool_ready,
  input  logic [POOL_BW-1:0] i_pool_data,
  output logic [ADDR_BW-1:0] o_rom_addr,
  input  logic [WGT_BW-1:0]  i_rom_data,
  output logic               o_kern_valid,
  output logic [POOL_BW-1:0] o_kern_pool,
  output logic [WGT_BW-1:0]  o_kern_weight,
  input  logic               i_kern_valid,
  input  logic [KR_BW-1:0]   i_kern_result,
  output logic               o_ch_valid,
  input  logic               i_ch_ready,
  output logic [OUT_BW-1:0]  o_ch_data,
  output logic [IDX_BW-1:0]  o_ch_idx,
  output logic               o_busy,
  output logic               o_frame_done
);

  localparam logic [K_BW-1:0]    K_LAST  = K_BW'(KLEN - 1);
  localparam logic [IDX_BW-1:0]  CO_LAST = IDX_BW'(CO - 1);
  localparam logic [RCNT_BW-1:0] R_FULL  = RCNT_BW'(KLEN);
  localparam logic [ADDR_BW-1:0] KLEN_A  = ADDR_BW'(KLEN);

  state_t               state_reg, state_next;
  logic [K_BW-1:0]      k_reg;
  logic [IDX_BW-1:0]    co_reg;
  logic [RCNT_BW-1:0]   rcnt_reg;
  logic [RCNT_BW-1:0]   rcnt_next;
  logic [ACC_BW-1:0]    acc_reg;
  logic [POOL_BW-1:0]   buf_mem [KLEN];
  logic                 kv_reg;
  logic [POOL_BW-1:0]   kpool_reg;
  logic signed [OUT_BW-1:0] sat_data;

  logic load_fire;   // pooled vector accepted this cycle
  logic acc_en;      // kernel result accepted this cycle
  logic ch_fire;     // channel result accepted downstream this cycle

  assign load_fire = (state_reg == ST_LOAD) && i_pool_valid;
  assign acc_en    = i_kern_valid && ((state_reg == ST_RUN) || (state_reg == ST_DRAIN));
  assign ch_fire   = (state_reg == ST_OUT) && i_ch_ready;
  assign rcnt_next = rcnt_reg + RCNT_BW'(acc_en);

  // State register; reset and clear both land in IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; the channel moves to OUT in the cycle its last result arrives
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (i_pool_valid) state_next = ST_LOAD;
      ST_LOAD:  if (load_fire && (k_reg == K_LAST)) state_next = ST_RUN;
      ST_RUN:   if (k_reg == K_LAST) state_next = ST_DRAIN;
      ST_DRAIN: if (rcnt_next == R_FULL) state_next = ST_OUT;
      ST_OUT: begin
        if (ch_fire) begin
          state_next = (co_reg == CO_LAST) ? ST_DONE : ST_RUN;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (i_clear) begin
      state_next = ST_IDLE;
    end
  end

  // Position/channel counters, result counter and the channel accumulator
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_reg    <= '0;
      co_reg   <= '0;
      rcnt_reg <= '0;
      acc_reg  <= '0;
    end else if (i_clear) begin
      k_reg    <= '0;
      co_reg   <= '0;
      rcnt_reg <= '0;
      acc_reg  <= '0;
    end else begin
      case (state_reg)
        ST_LOAD: begin
          if (load_fire) begin
            k_reg <= (k_reg == K_LAST) ? '0 : k_reg + 1'b1;
            if (k_reg == K_LAST) begin
              co_reg   <= '0;
              acc_reg  <= '0;
              rcnt_reg <= '0;
            end
          end
        end
        ST_RUN: begin
          k_reg <= (k_reg == K_LAST) ? '0 : k_reg + 1'b1;
        end
        ST_OUT: begin
          if (ch_fire) begin
            acc_reg  <= '0;
            rcnt_reg <= '0;
            k_reg    <= '0;
            co_reg   <= (co_reg == CO_LAST) ? '0 : co_reg + 1'b1;
          end
        end
        default: ;
      endcase
      // Results only count while this channel is being computed
      if (acc_en) begin
        acc_reg  <= acc_reg + {{(ACC_BW-KR_BW){i_kern_result[KR_BW-1]}}, i_kern_result};
        rcnt_reg <= rcnt_next;
      end
    end
  end

  // Pooled-vector buffer, one register bank per kernel position
  generate
    for (genvar gi = 0; gi < KLEN; gi++) begin : g_buf
      // Capture the vector for position gi when it is accepted
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          buf_mem[gi] <= '0;
        end else if (load_fire && (k_reg == K_BW'(gi))) begin
          buf_mem[gi] <= i_pool_data;
        end
      end
    end
  endgenerate

  // Issue stage: aligns the buffered feature with the ROM word fetched last cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kv_reg    <= 1'b0;
      kpool_reg <= '0;
    end else if (i_clear) begin
      kv_reg    <= 1'b0;
      kpool_reg <= '0;
    end else begin
      kv_reg <= (state_reg == ST_RUN);
      if (state_reg == ST_RUN) begin
        kpool_reg <= buf_mem[k_reg];
      end
    end
  end

  stage3_sat_round #(
    .IN_BW  (ACC_BW),
    .OUT_BW (OUT_BW)
  ) u_sat (
    .in_data  (acc_reg),
    .out_data (sat_data)
  );

  assign o_pool_ready  = (state_reg == ST_LOAD);
  assign o_rom_addr    = (state_reg == ST_RUN) ? (ADDR_BW'(co_reg) * KLEN_A + ADDR_BW'(k_reg)) : '0;
  assign o_kern_valid  = kv_reg;
  assign o_kern_pool   = kpool_reg;
  assign o_kern_weight = kv_reg ? i_rom_data : '0;
  assign o_ch_valid    = (state_reg == ST_OUT);
  assign o_ch_data     = (state_reg == ST_OUT) ? sat_data : '0;
  assign o_ch_idx      = (state_reg == ST_OUT) ? co_reg : '0;
  assign o_busy        = (state_reg != ST_IDLE);
  assign o_frame_done  = (state_reg == ST_DONE);

endmodule

// File: tb/tb_stage3_kernel_scheduler.sv
// Bench for stage3_kernel_scheduler: models the weight ROM and the 2-cycle
// MAC kernel, and scores each channel result against a queue of expectations.
module tb_stage3_kernel_scheduler;
  import stage3_kernel_scheduler_pkg::*;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               i_clear = 1'b0;
  logic               i_pool_valid = 1'b0;
  logic               o_pool_ready;
  logic [POOL_BW-1:0] i_pool_data = '0;
  logic [ADDR_BW-1:0] o_rom_addr;
  logic [WGT_BW-1:0]  i_rom_data;
  logic               o_kern_valid;
  logic [POOL_BW-1:0] o_kern_pool;
  logic [WGT_BW-1:0]  o_kern_weight;
  logic               i_kern_valid;
  logic [KR_BW-1:0]   i_kern_result;
  logic               o_ch_valid;
  logic               i_ch_ready = 1'b1;
  logic [OUT_BW-1:0]  o_ch_data;
  logic [IDX_BW-1:0]  o_ch_idx;
  logic               o_busy;
  logic               o_frame_done;

  stage3_kernel_scheduler dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_clear       (i_clear),
    .i_pool_valid  (i_pool_valid),
    .o_pool_ready  (o_pool_ready),
    .i_pool_data   (i_pool_data),
    .o_rom_addr    (o_rom_addr),
    .i_rom_data    (i_rom_data),
    .o_kern_valid  (o_kern_valid),
    .o_kern_pool   (o_kern_pool),
    .o_kern_weight (o_kern_weight),
    .i_kern_valid  (i_kern_valid),
    .i_kern_result (i_kern_result),
    .o_ch_valid    (o_ch_valid),
    .i_ch_ready    (i_ch_ready),
    .o_ch_data     (o_ch_data),
    .o_ch_idx      (o_ch_idx),
    .o_busy        (o_busy),
    .o_frame_done  (o_frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int exp_done = 0;

  typedef struct {
    int     idx;
    longint data;
  } sb_t;
  sb_t exp_q[$];

  logic [WGT_BW-1:0]  rom_mem [16];
  logic [POOL_BW-1:0] pool_vec [KLEN];
  logic [WGT_BW-1:0]  rom_q = '0;
  logic               kv1 = 1'b0, kv2 = 1'b0;
  logic [KR_BW-1:0]   kr1 = '0, kr2 = '0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic longint dot(input logic [POOL_BW-1:0] p, input logic [WGT_BW-1:0] w);
    longint s;
    logic signed [OF_BW-1:0] a;
    logic signed [W_BW-1:0]  b;
    s = 0;
    for (int c = 0; c < CI; c++) begin
      a = p[c*OF_BW +: OF_BW];
      b = w[c*W_BW +: W_BW];
      s += longint'(a) * longint'(b);
    end
    return s;
  endfunction

  function automatic longint sat(input longint s);
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  function automatic logic [POOL_BW-1:0] ppack(input int a, input int b, input int c);
    return {OF_BW'(c), OF_BW'(b), OF_BW'(a)};
  endfunction

  function automatic logic [WGT_BW-1:0] wpack(input int a, input int b, input int c);
    return {W_BW'(c), W_BW'(b), W_BW'(a)};
  endfunction

  // Weight ROM: one cycle read latency
  always @(posedge clk) rom_q <= rom_mem[o_rom_addr];
  assign i_rom_data = rom_q;

  // MAC kernel model: dot product, two cycles of latency
  always @(posedge clk) begin
    kv1 <= o_kern_valid;
    kr1 <= KR_BW'(dot(o_kern_pool, o_kern_weight));
    kv2 <= kv1;
    kr2 <= kr1;
  end
  assign i_kern_valid  = kv2;
  assign i_kern_result = kr2;

  // Scoreboard: score every accepted channel result, count frame_done pulses
  always @(negedge clk) begin
    sb_t e;
    if (reset_n && o_ch_valid && i_ch_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ch", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("ch_data", longint'($signed(o_ch_data)), e.data);
        check("ch_idx", longint'(o_ch_idx), longint'(e.idx));
        $display("ch idx=%0d data=%0d exp=%0d", o_ch_idx, $signed(o_ch_data), e.data);
      end
    end
    if (reset_n && o_frame_done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_weights(input int co, input logic [WGT_BW-1:0] w);
    for (int k = 0; k < KLEN; k++) rom_mem[co*KLEN + k] = w;
  endtask

  task automatic set_pool(input logic [POOL_BW-1:0] p);
    for (int k = 0; k < KLEN; k++) pool_vec[k] = p;
  endtask

  task automatic push_expected();
    longint s;
    for (int co = 0; co < CO; co++) begin
      s = 0;
      for (int k = 0; k < KLEN; k++) s += dot(pool_vec[k], rom_mem[co*KLEN + k]);
      exp_q.push_back('{idx: co, data: sat(s)});
    end
    exp_done++;
  endtask

  // Feed the buffered frame, honouring o_pool_ready, with optional idle gaps
  task automatic load_frame(input int gap);
    bit rdy, took;
    int guard;
    for (int k = 0; k < KLEN; k++) begin
      i_pool_valid = 1'b1;
      i_pool_data  = pool_vec[k];
      took  = 1'b0;
      guard = 0;
      while (!took) begin
        rdy = o_pool_ready;
        tick();
        if (rdy) took = 1'b1;
        else if (++guard > 20) begin
          check("load_timeout", 0, 1);
          i_pool_valid = 1'b0;
          return;
        end
      end
      for (int g = 0; g < gap; g++) begin
        i_pool_valid = 1'b0;
        tick();
      end
    end
    i_pool_valid = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    int guard;
    guard = 0;
    while ((done_cnt < exp_done) && (guard < 300)) begin
      tick();
      guard++;
    end
    repeat (3) tick();
    check({tag, "_done_cnt"}, done_cnt, exp_done);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
    check({tag, "_idle"}, o_busy, 0);
  endtask

  task automatic random_frame();
    for (int k = 0; k < KLEN; k++)
      pool_vec[k] = ppack(int'($urandom_range(200)) - 100, int'($urandom_range(200)) - 100,
                          int'($urandom_range(200)) - 100);
    for (int a = 0; a < CO*KLEN; a++)
      rom_mem[a] = wpack(int'($urandom_range(40)) - 20, int'($urandom_range(40)) - 20,
                         int'($urandom_range(40)) - 20);
  endtask

  initial begin
    int guard;
    for (int a = 0; a < 16; a++) rom_mem[a] = '0;
    for (int k = 0; k < KLEN; k++) pool_vec[k] = '0;

    // Reset state
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check("rst_busy", o_busy, 0);
    check("rst_pool_ready", o_pool_ready, 0);
    check("rst_kern_valid", o_kern_valid, 0);
    check("rst_ch_valid", o_ch_valid, 0);
    check("rst_frame_done", o_frame_done, 0);
    check("rst_rom_addr", o_rom_addr, 0);
    check("rst_ch_data", o_ch_data, 0);

    // 1: all ones -> 12 per channel
    set_pool(ppack(1, 1, 1));
    for (int co = 0; co < CO; co++) set_weights(co, wpack(1, 1, 1));
    push_expected();
    load_frame(0);
    wait_frame("ones");

    // 2: signed operands, ch0 = 4*(-8+3) = -20
    set_pool(ppack(-2, 3, 0));
    set_weights(0, wpack(4, 1, -5));
    set_weights(1, wpack(1, 2, 3));
    set_weights(2, wpack(-1, -1, -1));
    push_expected();
    load_frame(0);
    wait_frame("signed");

    // 3: saturation at both rails
    set_pool(ppack(32767, 32767, 32767));
    set_weights(0, wpack(127, 127, 127));
    set_weights(1, wpack(127, 127, 127));
    set_weights(2, wpack(-128, -128, -128));
    push_expected();
    load_frame(0);
    wait_frame("sat");

    // 4: backpressure in OUT for 5 cycles
    random_frame();
    push_expected();
    i_ch_ready = 1'b0;
    load_frame(0);
    guard = 0;
    while (!o_ch_valid && guard < 50) begin
      tick();
      guard++;
    end
    check("bp_reach_out", o_ch_valid, 1);
    for (int c = 0; c < 5; c++) begin
      check("bp_data", longint'($signed(o_ch_data)), exp_q[0].data);
      check("bp_idx", longint'(o_ch_idx), longint'(exp_q[0].idx));
      check("bp_no_issue", o_kern_valid, 0);
      tick();
    end
    i_ch_ready = 1'b1;
    wait_frame("bp");

    // 5: pool valid every 3rd cycle, then valid held during RUN
    set_pool(ppack(1, 1, 1));
    for (int co = 0; co < CO; co++) set_weights(co, wpack(1, 1, 1));
    push_expected();
    load_frame(2);
    i_pool_valid = 1'b1;
    i_pool_data  = ppack(999, 999, 999);
    for (int c = 0; c < 3; c++) begin
      check("run_pool_ready", o_pool_ready, 0);
      tick();
    end
    i_pool_valid = 1'b0;
    wait_frame("gaps");

    // 6: clear mid-DRAIN, in-flight results dropped, next frame clean
    random_frame();
    load_frame(0);
    repeat (4) tick();
    check("pre_clear_busy", o_busy, 1);
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    check("clear_busy", o_busy, 0);
    check("clear_kern_valid", o_kern_valid, 0);
    check("clear_ch_valid", o_ch_valid, 0);
    repeat (4) tick();
    check("clear_stays_idle", o_busy, 0);
    set_pool(ppack(1, 1, 1));
    for (int co = 0; co < CO; co++) set_weights(co, wpack(1, 1, 1));
    push_expected();
    load_frame(0);
    wait_frame("after_clear");

    // 7: asynchronous reset mid-DRAIN, then a clean signed frame
    random_frame();
    load_frame(0);
    repeat (4) tick();
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_busy", o_busy, 0);
    check("rst_async_kern_valid", o_kern_valid, 0);
    tick();
    reset_n = 1'b1;
    repeat (4) tick();
    set_pool(ppack(-2, 3, 0));
    set_weights(0, wpack(4, 1, -5));
    set_weights(1, wpack(7, -3, 2));
    set_weights(2, wpack(-6, 5, 1));
    push_expected();
    load_frame(0);
    wait_frame("after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
